store_monitor: RTL and testbench
================================

Name: store_monitor

Overview:
- Self-checking observer that sits directly downstream of the multicycle processor top, on its external memory-write bus (adr, writedata, memwrite).
- Logs every store into a small FIFO for bench readout.
- Judges the first store after arming against an expected value and reports pass, fail or timeout as sticky flags.
- Gives the synthesisable and simulation flows one shared store checker.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TIMEOUT, 1024, cycles after arm with no store before the timeout verdict; at least 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low; reset==0 at a rising clk edge resets the block
- adr  input  32  processor memory address
- writedata  input  32  processor store data
- memwrite  input  1  store strobe; each high cycle is one store event
- arm  input  1  one-cycle pulse; latches the expected value and starts a check
- expect_data  input  32  expected store data, sampled on arm
- pop  input  1  consume the FIFO head
- log_valid  output  1  FIFO not empty
- log_adr  output  32  address at the FIFO head
- log_data  output  32  data at the FIFO head
- log_count  output  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky; a store was dropped because the FIFO was full
- busy  output  1  state is ARMED
- pass  output  1  sticky verdict
- fail  output  1  sticky verdict
- timeout  output  1  sticky verdict

Behaviour:
- Reset, when reset==0 at a clk edge:
  - state=IDLE; FIFO empty; log_count=0; log_valid=0.
  - log_adr=0, log_data=0, overflow=0, busy=0, pass=0, fail=0, timeout=0.
  - Cycle counter=0.
  - Reset mid-check abandons the check; no verdict is set.
- FIFO: registered, pointer-based, first-word fall-through.
  - Push on any cycle with memwrite=1 (all states). The entry is {adr, writedata} as sampled at that edge.
  - log_adr and log_data are driven from the head entry; they read 0 when the FIFO is empty.
  - Pop when pop=1 and log_valid=1. A pop on an empty FIFO is ignored.
  - Push while full with no pop: the entry is dropped, overflow is set, contents are unchanged.
  - Push and pop together while full: both happen, count unchanged, no overflow.
  - Push and pop together while empty: push only.
  - Pointers wrap modulo DEPTH.
  - log_count updates one cycle after the edge that caused the change.
- FSM states: IDLE, ARMED, DONE.
  - IDLE, arm=1: latch expect_data; clear pass, fail and timeout; counter=0; go to ARMED.
  - ARMED, memwrite=1:
    - writedata===expected sets pass; otherwise set fail. The compare is a full 32-bit equality.
    - Go to DONE. The verdict is visible the cycle after the store edge.
  - ARMED, memwrite=0: counter increments.
    - At the edge where counter reaches TIMEOUT-1: set timeout, go to DONE.
    - A store on that same edge takes priority over timeout.
  - ARMED, arm=1: re-arm. Relatch, counter=0; a store on the same edge is still judged against the old value.
  - DONE, arm=1: same as from IDLE.
  - DONE otherwise: hold. Verdicts are sticky until arm or reset.
- At most one of pass, fail, timeout is high at any time.
- busy = (state==ARMED).

Optional Feature:
- Macro STORE_MONITOR_ADDR_MATCH_EN.
- Defined:
  - Adds input expect_adr[31:0], sampled on arm.
  - In ARMED, only stores with adr==expect_adr are judged. Other stores are logged only and do not reset the timeout counter.
- Undefined:
  - No expect_adr port.
  - The first store in ARMED is judged whatever its address.

Test Plan:
- Reset, arm with expect_data=32'hFFFF7F02, then one cycle memwrite=1, adr=84, writedata=32'hFFFF7F02 -> next cycle: pass=1, busy=0, log_valid=1, log_adr=84, log_data=32'hFFFF7F02, log_count=1.
- Arm with expect_data=7, store writedata=5 -> fail=1, pass=0. Re-arm with expect_data=5 -> fail clears the cycle after arm.
- TIMEOUT=16, arm, no stores -> timeout=1 exactly 16 cycles after the arm edge. A store on cycle 16 instead -> pass or fail set, timeout=0.
- DEPTH=8: 9 consecutive stores with data 1..9, no pop -> log_count=8, overflow=1. Pop 8 times -> data 1..8 in order, then log_valid=0.
- FIFO full, then memwrite and pop together -> log_count stays 8, overflow stays 0. With the FIFO empty, pop alone -> log_count stays 0.
- Arm, then hold reset=0 for one cycle during ARMED -> all outputs 0 and state IDLE. A following store is logged but sets no verdict.

Source files
------------

// File: rtl/store_monitor.sv
// ---------------------------------------------------------------------------
// store_monitor
//
// Observer on the processor's external memory-write bus. Every store is
// logged into a small first-word-fall-through FIFO that a bench can drain,
// and the first store after an arm pulse is judged against an expected data
// word, producing sticky pass / fail / timeout verdicts.
//
// Parameters
//   DEPTH    FIFO entries (power of two, >= 2)
//   TIMEOUT  store-free cycles after arm before the timeout verdict (>= 2)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   adr          processor store address
//   writedata    processor store data
//   memwrite     store strobe, one store per high cycle
//   arm          one-cycle pulse, latches expect_data and starts a check
//   expect_data  expected store data, sampled on arm
//   expect_adr   expected store address (only with the macro below)
//   pop          consume the FIFO head
//   log_valid    FIFO not empty
//   log_adr      address at the FIFO head (0 when empty)
//   log_data     data at the FIFO head (0 when empty)
//   log_count    FIFO occupancy
//   overflow     sticky, a store was dropped because the FIFO was full
//   busy         a check is in progress
//   pass/fail/timeout  sticky verdicts, cleared by arm or reset
//
// Optional feature macro: STORE_MONITOR_ADDR_MATCH_EN
//   When defined, adds expect_adr; while armed only stores to that address
//   are judged, other stores are just logged.
// ---------------------------------------------------------------------------
module store_monitor #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            adr,
  input  logic [31:0]            writedata,
  input  logic                   memwrite,
  input  logic                   arm,
  input  logic [31:0]            expect_data,
`ifdef STORE_MONITOR_ADDR_MATCH_EN
  input  logic [31:0]            expect_adr,
`endif
  input  logic                   pop,
  output logic                   log_valid,
  output logic [31:0]            log_adr,
  output logic [31:0]            log_data,
  output logic [$clog2(DEPTH):0] log_count,
  output logic                   overflow,
  output logic                   busy,
  output logic                   pass,
  output logic                   fail,
  output logic                   timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [TW-1:0] LAST_COUNT = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  // FIFO storage and bookkeeping
  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [63:0]   w_head;

  // Checker state
  state_t        r_state, w_nextState;
  logic [31:0]   r_expData, w_nextExpData;
  logic [TW-1:0] r_cnt, w_nextCnt;
  logic          r_pass, w_nextPass;
  logic          r_fail, w_nextFail;
  logic          r_timeout, w_nextTimeout;
  logic          w_judge;
`ifdef STORE_MONITOR_ADDR_MATCH_EN
  logic [31:0]   r_expAdr, w_nextExpAdr;
`endif

  // A pop only counts when there is something to pop. When full, a
  // simultaneous pop frees the slot so the incoming store still fits.
  assign w_full = (r_count == FULL_COUNT);
  assign w_pop  = pop && (r_count != '0);
  assign w_push = memwrite && (!w_full || w_pop);
  assign w_drop = memwrite && w_full && !w_pop;

  // Storage array needs no reset: the head is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= {adr, writedata};
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign w_head    = r_mem[r_rdPtr];
  assign log_valid = (r_count != '0);
  assign log_adr   = log_valid ? w_head[63:32] : '0;
  assign log_data  = log_valid ? w_head[31:0]  : '0;
  assign log_count = r_count;
  assign overflow  = r_overflow;

`ifdef STORE_MONITOR_ADDR_MATCH_EN
  assign w_judge = memwrite && (adr == r_expAdr);
`else
  assign w_judge = memwrite;
`endif

  // Checker state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_expData <= '0;
      r_cnt     <= '0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
`ifdef STORE_MONITOR_ADDR_MATCH_EN
      r_expAdr  <= '0;
`endif
    end else begin
      r_state   <= w_nextState;
      r_expData <= w_nextExpData;
      r_cnt     <= w_nextCnt;
      r_pass    <= w_nextPass;
      r_fail    <= w_nextFail;
      r_timeout <= w_nextTimeout;
`ifdef STORE_MONITOR_ADDR_MATCH_EN
      r_expAdr  <= w_nextExpAdr;
`endif
    end
  end

  // Next-state logic. In ARMED a judged store wins over both re-arm and
  // timeout, and it is compared against the value latched before this edge.
  always_comb begin
    w_nextState   = r_state;
    w_nextExpData = r_expData;
    w_nextCnt     = r_cnt;
    w_nextPass    = r_pass;
    w_nextFail    = r_fail;
    w_nextTimeout = r_timeout;
`ifdef STORE_MONITOR_ADDR_MATCH_EN
    w_nextExpAdr  = r_expAdr;
    if (arm) w_nextExpAdr = expect_adr;
`endif
    if (arm) w_nextExpData = expect_data;
    case (r_state)
      IDLE, DONE: begin
        if (arm) begin
          w_nextPass    = 1'b0;
          w_nextFail    = 1'b0;
          w_nextTimeout = 1'b0;
          w_nextCnt     = '0;
          w_nextState   = ARMED;
        end
      end
      ARMED: begin
        if (w_judge) begin
          w_nextPass  = (writedata == r_expData);
          w_nextFail  = (writedata != r_expData);
          w_nextState = DONE;
        end else if (arm) begin
          w_nextCnt = '0;
        end else if (r_cnt == LAST_COUNT) begin
          w_nextTimeout = 1'b1;
          w_nextState   = DONE;
        end else begin
          w_nextCnt = r_cnt + TW'(1);
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign busy    = (r_state == ARMED);
  assign pass    = r_pass;
  assign fail    = r_fail;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_store_monitor.sv
// ---------------------------------------------------------------------------
// tb_store_monitor
//
// Bench for store_monitor with DEPTH=8 and TIMEOUT=16. A table of directed
// vectors walks through the basic pass/fail/re-arm flow, hand-written
// sequences cover timeout, FIFO overflow and mid-check reset, and a long
// randomized run is checked cycle by cycle against a queue-based model.
// ---------------------------------------------------------------------------
module tb_store_monitor;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] CHK_ADR = 32'd84;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic        arm;
  logic [31:0] expect_data;
  logic        pop;
  logic        log_valid;
  logic [31:0] log_adr;
  logic [31:0] log_data;
  logic [3:0]  log_count;
  logic        overflow;
  logic        busy;
  logic        pass;
  logic        fail;
  logic        timeout;
`ifdef STORE_MONITOR_ADDR_MATCH_EN
  logic [31:0] expect_adr;
  assign expect_adr = CHK_ADR;
`endif

  int nChecks      = 0;
  int nMiscompares = 0;

  store_monitor #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .adr         (adr),
    .writedata   (writedata),
    .memwrite    (memwrite),
    .arm         (arm),
    .expect_data (expect_data),
`ifdef STORE_MONITOR_ADDR_MATCH_EN
    .expect_adr  (expect_adr),
`endif
    .pop         (pop),
    .log_valid   (log_valid),
    .log_adr     (log_adr),
    .log_data    (log_data),
    .log_count   (log_count),
    .overflow    (overflow),
    .busy        (busy),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO as a queue, check as "armed + store-free edges"
  logic [63:0] mQ[$];
  bit          mArmed = 0;
  bit          mPass  = 0;
  bit          mFail  = 0;
  bit          mTo    = 0;
  bit          mOvf   = 0;
  logic [31:0] mExp   = '0;
  int          mIdle  = 0;

  task automatic modelStep();
    bit popOk;
    bit judged;
    if (!reset) begin
      mQ.delete();
      mArmed = 0; mPass = 0; mFail = 0; mTo = 0; mOvf = 0;
      mExp = '0; mIdle = 0;
    end else begin
      popOk = pop && (mQ.size() > 0);
      if (popOk) void'(mQ.pop_front());
      if (memwrite) begin
        if (mQ.size() < DEPTH) mQ.push_back({adr, writedata});
        else mOvf = 1;
      end
`ifdef STORE_MONITOR_ADDR_MATCH_EN
      judged = memwrite && (adr == CHK_ADR);
`else
      judged = memwrite;
`endif
      if (mArmed) begin
        if (judged) begin
          mPass  = (writedata == mExp);
          mFail  = !mPass;
          mArmed = 0;
        end else if (arm) begin
          mIdle = 0;
        end else begin
          mIdle++;
          if (mIdle == TIMEOUT) begin
            mTo    = 1;
            mArmed = 0;
          end
        end
      end else if (arm) begin
        mPass = 0; mFail = 0; mTo = 0;
        mIdle = 0;
        mArmed = 1;
      end
      if (arm) mExp = expect_data;
    end
  endtask

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model and settle
  task automatic applyStimulus(input logic r, input logic mw, input logic [31:0] a,
                               input logic [31:0] wd, input logic ar,
                               input logic [31:0] ed, input logic pp);
    reset = r; memwrite = mw; adr = a; writedata = wd;
    arm = ar; expect_data = ed; pop = pp;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkOutput();
    logic [31:0] headAdr;
    logic [31:0] headData;
    headAdr  = (mQ.size() > 0) ? mQ[0][63:32] : 32'd0;
    headData = (mQ.size() > 0) ? mQ[0][31:0]  : 32'd0;
    compare("model.log_valid", {31'd0, log_valid}, {31'd0, mQ.size() > 0});
    compare("model.log_adr", log_adr, headAdr);
    compare("model.log_data", log_data, headData);
    compare("model.log_count", {28'd0, log_count}, mQ.size());
    compare("model.overflow", {31'd0, overflow}, {31'd0, mOvf});
    compare("model.busy", {31'd0, busy}, {31'd0, mArmed});
    compare("model.pass", {31'd0, pass}, {31'd0, mPass});
    compare("model.fail", {31'd0, fail}, {31'd0, mFail});
    compare("model.timeout", {31'd0, timeout}, {31'd0, mTo});
    compare("verdictOneHot", {31'd0, (32'(pass) + 32'(fail) + 32'(timeout)) <= 1}, 32'd1);
  endtask

  typedef struct {
    logic        rst;
    logic        mw;
    logic [31:0] a;
    logic [31:0] wd;
    logic        ar;
    logic [31:0] ed;
    logic        pp;
    logic        eValid;
    logic [31:0] eAdr;
    logic [31:0] eData;
    logic [3:0]  eCount;
    logic        eBusy;
    logic        ePass;
    logic        eFail;
  } vec_t;

  vec_t vecs[8];

  task automatic checkVector(input int idx);
    vec_t v;
    v = vecs[idx];
    compare($sformatf("vec%0d.log_valid", idx), {31'd0, log_valid}, {31'd0, v.eValid});
    compare($sformatf("vec%0d.log_adr", idx), log_adr, v.eAdr);
    compare($sformatf("vec%0d.log_data", idx), log_data, v.eData);
    compare($sformatf("vec%0d.log_count", idx), {28'd0, log_count}, {28'd0, v.eCount});
    compare($sformatf("vec%0d.busy", idx), {31'd0, busy}, {31'd0, v.eBusy});
    compare($sformatf("vec%0d.pass", idx), {31'd0, pass}, {31'd0, v.ePass});
    compare($sformatf("vec%0d.fail", idx), {31'd0, fail}, {31'd0, v.eFail});
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    checkOutput();
  endtask

  task automatic resetCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    checkOutput();
  endtask

  initial begin
    int storeOdds;
    logic rr, mw, ar, pp;
    logic [31:0] a, wd, ed;

    // rst mw  adr      wdata          arm exp            pop | valid adr      data           cnt busy pass fail
    vecs[0] = '{1'b0, 1'b0, 32'd0,  32'd0,        1'b0, 32'd0,        1'b0, 1'b0, 32'd0,  32'd0,        4'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'd0,  32'd0,        1'b1, 32'hFFFF7F02, 1'b0, 1'b0, 32'd0,  32'd0,        4'd0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'd84, 32'hFFFF7F02, 1'b0, 32'd0,        1'b0, 1'b1, 32'd84, 32'hFFFF7F02, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'd0,  32'd0,        1'b0, 32'd0,        1'b1, 1'b0, 32'd0,  32'd0,        4'd0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'd0,  32'd0,        1'b1, 32'd7,        1'b0, 1'b0, 32'd0,  32'd0,        4'd0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'd84, 32'd5,        1'b0, 32'd0,        1'b0, 1'b1, 32'd84, 32'd5,        4'd1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'd0,  32'd0,        1'b1, 32'd5,        1'b1, 1'b0, 32'd0,  32'd0,        4'd0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 32'd0,  32'd0,        1'b0, 32'd0,        1'b1, 1'b0, 32'd0,  32'd0,        4'd0, 1'b1, 1'b0, 1'b0};

    $display("[TB] directed vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].mw, vecs[i].a, vecs[i].wd,
                    vecs[i].ar, vecs[i].ed, vecs[i].pp);
      checkVector(i);
      checkOutput();
    end

    $display("[TB] timeout after 16 store-free cycles");
    resetCycle();
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 32'h1234, 1'b0);
    checkOutput();
    for (int i = 1; i < TIMEOUT; i++) idleCycle();
    compare("timeout.cycle15", {31'd0, timeout}, 32'd0);
    compare("timeout.busy15", {31'd0, busy}, 32'd1);
    idleCycle();
    compare("timeout.cycle16", {31'd0, timeout}, 32'd1);
    compare("timeout.busy16", {31'd0, busy}, 32'd0);

    $display("[TB] store on cycle 16 beats timeout");
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 32'hCAFE, 1'b0);
    checkOutput();
    for (int i = 1; i < TIMEOUT; i++) idleCycle();
    applyStimulus(1'b1, 1'b1, CHK_ADR, 32'hCAFE, 1'b0, '0, 1'b0);
    checkOutput();
    compare("lateStore.pass", {31'd0, pass}, 32'd1);
    compare("lateStore.timeout", {31'd0, timeout}, 32'd0);

    $display("[TB] overflow with 9 stores");
    resetCycle();
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 1'b1, CHK_ADR, 32'(i), 1'b0, '0, 1'b0);
      checkOutput();
    end
    compare("ovf.count", {28'd0, log_count}, 32'd8);
    compare("ovf.flag", {31'd0, overflow}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      compare($sformatf("ovf.drain%0d", i), log_data, 32'(i));
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
      checkOutput();
    end
    compare("ovf.emptyValid", {31'd0, log_valid}, 32'd0);

    $display("[TB] push and pop together while full");
    resetCycle();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b1, CHK_ADR, 32'(i), 1'b0, '0, 1'b0);
      checkOutput();
    end
    applyStimulus(1'b1, 1'b1, CHK_ADR, 32'd9, 1'b0, '0, 1'b1);
    checkOutput();
    compare("fullPushPop.count", {28'd0, log_count}, 32'd8);
    compare("fullPushPop.ovf", {31'd0, overflow}, 32'd0);
    compare("fullPushPop.head", log_data, 32'd2);

    $display("[TB] pop on empty, push+pop on empty");
    resetCycle();
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    checkOutput();
    compare("emptyPop.count", {28'd0, log_count}, 32'd0);
    applyStimulus(1'b1, 1'b1, CHK_ADR, 32'hAB, 1'b0, '0, 1'b1);
    checkOutput();
    compare("emptyPushPop.count", {28'd0, log_count}, 32'd1);

    $display("[TB] reset during an armed check");
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 32'h55, 1'b0);
    checkOutput();
    resetCycle();
    compare("midReset.busy", {31'd0, busy}, 32'd0);
    compare("midReset.count", {28'd0, log_count}, 32'd0);
    compare("midReset.verdicts", {29'd0, pass, fail, timeout}, 32'd0);
    applyStimulus(1'b1, 1'b1, CHK_ADR, 32'h55, 1'b0, '0, 1'b0);
    checkOutput();
    compare("postReset.logged", {31'd0, log_valid}, 32'd1);
    compare("postReset.verdicts", {29'd0, pass, fail, timeout}, 32'd0);

    $display("[TB] randomized run against model");
    for (int c = 0; c < 4000; c++) begin
      storeOdds = (((c / 250) % 2) == 0) ? 4 : 40;
      rr = ($urandom_range(0, 99) != 0);
      mw = ($urandom_range(0, storeOdds - 1) == 0);
      ar = !mw && ($urandom_range(0, 11) == 0);
      a  = ($urandom_range(0, 1) == 1) ? CHK_ADR : $urandom;
      wd = ($urandom_range(0, 2) == 0) ? mExp : $urandom;
      ed = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
      pp = ($urandom_range(0, 2) == 0);
      applyStimulus(rr, mw, a, wd, ar, ed, pp);
      checkOutput();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiscompares);
    $finish;
  end

endmodule
